// File: rtl/pwl_filter_lock_sequencer_if.sv
// Control/filter bundle for the PWL filter lock sequencer.
// master = bring-up controller side, slave = sequencer.
interface pwl_filter_lock_sequencer_if #(
   parameter int CW = 8
);
   logic          start;
   logic          abort;
   logic [CW-1:0] n_rst;
   logic [CW-1:0] n_fast;
   logic [CW-1:0] n_settle;
   logic          filt_reset;
   real           fp1;
   real           fp_rst;
   logic          busy;
   logic          ready;
   logic          done;
   logic [2:0]    state;

   modport master (
      output start, abort, n_rst, n_fast, n_settle,
      input  filt_reset, fp1, fp_rst,
      input  busy, ready, done, state
   );

   modport slave (
      input  start, abort, n_rst, n_fast, n_settle,
      output filt_reset, fp1, fp_rst,
      output busy, ready, done, state
   );
endinterface

// File: rtl/pwl_filter_lock_sequencer.sv
// Sequences a PWL filter through reset / fast-acquire / settle / locked.
// All outputs are registered and decoded from the next state.
module pwl_filter_lock_sequencer #(
   parameter int  CW         = 8,
   parameter real fp1_nom    = 1e6,
   parameter real fp1_fast   = 1e7,
   parameter real fp_rst_val = 0.0
) (
   input  logic clk,
   input  logic rst,
   pwl_filter_lock_sequencer_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_RESET  = 3'd1,
      S_FAST   = 3'd2,
      S_SETTLE = 3'd3,
      S_LOCKED = 3'd4
   } state_t;

   state_t        st, st_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic [CW-1:0] lat_fast, lat_settle;
   logic          ld;
   logic          filt_reset_q, busy_q, ready_q, done_q;
   real           fp1_q;

   // A zero count still yields a one-cycle phase.
   function automatic logic [CW-1:0] m1(input logic [CW-1:0] n);
      return (n == '0) ? '0 : n - 1'b1;
   endfunction

   always_comb begin
      st_nxt  = st;
      cnt_nxt = cnt;
      ld      = 1'b0;
      if (bus.abort) begin
         st_nxt  = S_IDLE;
         cnt_nxt = '0;
      end else begin
         unique case (st)
            S_IDLE, S_LOCKED: begin
               if (bus.start) begin
                  st_nxt  = S_RESET;
                  cnt_nxt = m1(bus.n_rst);
                  ld      = 1'b1;
               end
            end
            S_RESET: begin
               if (cnt == '0) begin
                  st_nxt  = S_FAST;
                  cnt_nxt = m1(lat_fast);
               end else begin
                  cnt_nxt = cnt - 1'b1;
               end
            end
            S_FAST: begin
               if (cnt == '0) begin
                  st_nxt  = S_SETTLE;
                  cnt_nxt = m1(lat_settle);
               end else begin
                  cnt_nxt = cnt - 1'b1;
               end
            end
            S_SETTLE: begin
               if (cnt == '0) begin
                  st_nxt  = S_LOCKED;
                  cnt_nxt = '0;
               end else begin
                  cnt_nxt = cnt - 1'b1;
               end
            end
            default: begin
               st_nxt  = S_IDLE;
               cnt_nxt = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         st           <= S_IDLE;
         cnt          <= '0;
         lat_fast     <= '0;
         lat_settle   <= '0;
         filt_reset_q <= 1'b0;
         busy_q       <= 1'b0;
         ready_q      <= 1'b0;
         done_q       <= 1'b0;
         fp1_q        <= fp1_nom;
      end else begin
         st  <= st_nxt;
         cnt <= cnt_nxt;
         if (ld) begin
            lat_fast   <= bus.n_fast;
            lat_settle <= bus.n_settle;
         end
         filt_reset_q <= (st_nxt == S_RESET);
         busy_q       <= (st_nxt == S_RESET) ||
                         (st_nxt == S_FAST) ||
                         (st_nxt == S_SETTLE);
         ready_q      <= (st_nxt == S_LOCKED);
         done_q       <= (st_nxt == S_LOCKED) &&
                         (st != S_LOCKED);
         fp1_q        <= (st_nxt == S_FAST) ? fp1_fast
                                            : fp1_nom;
      end
   end

   assign bus.state      = st;
   assign bus.filt_reset = filt_reset_q;
   assign bus.busy       = busy_q;
   assign bus.ready      = ready_q;
   assign bus.done       = done_q;
   assign bus.fp1        = fp1_q;
   assign bus.fp_rst     = fp_rst_val;

endmodule

// File: tb/tb_pwl_filter_lock_sequencer.sv
// Scoreboard bench for pwl_filter_lock_sequencer.
// Per-cycle expectations are queued with the stimulus, popped after each edge.
module tb_pwl_filter_lock_sequencer;

   localparam int CW = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;

   pwl_filter_lock_sequencer_if #(.CW(CW)) bus ();

   pwl_filter_lock_sequencer #(.CW(CW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0] st;
      logic       fr;
      logic       bsy;
      logic       rdy;
      logic       dn;
      longint     fp;
   } exp_t;

   exp_t sb[$];
   int   n_vec = 0;
   int   n_err = 0;

   task automatic chk(input string tag, input longint obs,
                      input longint exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, want %0d (t=%0t)",
                  tag, obs, exp, $time);
      end
   endtask

   function automatic exp_t mk(input int s, input bit dn);
      exp_t e;
      e.st  = 3'(s);
      e.fr  = (s == 1);
      e.bsy = (s >= 1) && (s <= 3);
      e.rdy = (s == 4);
      e.dn  = dn;
      e.fp  = (s == 2) ? 64'd10000000 : 64'd1000000;
      return e;
   endfunction

   task automatic plan(input int s, input int n,
                       input bit dn = 1'b0);
      for (int i = 0; i < n; i++) sb.push_back(mk(s, dn));
   endtask

   function automatic int leff(input int n);
      return (n == 0) ? 1 : n;
   endfunction

   task automatic plan_seq(input int nr, input int nf,
                           input int ns);
      plan(1, leff(nr));
      plan(2, leff(nf));
      plan(3, leff(ns));
      plan(4, 1, 1'b1);
   endtask

   // Clock through the queued plan; unless held, start/abort
   // are released after the first edge.
   task automatic drain(input bit hold);
      exp_t e;
      bit   first = 1'b1;
      while (sb.size() > 0) begin
         @(posedge clk);
         #1;
         if (!hold && first) begin
            bus.start = 1'b0;
            bus.abort = 1'b0;
         end
         first = 1'b0;
         e = sb.pop_front();
         chk("state", longint'(bus.state), longint'(e.st));
         chk("filt_reset", longint'(bus.filt_reset),
             longint'(e.fr));
         chk("busy", longint'(bus.busy), longint'(e.bsy));
         chk("ready", longint'(bus.ready), longint'(e.rdy));
         chk("done", longint'(bus.done), longint'(e.dn));
         chk("fp1", longint'($rtoi(bus.fp1)), e.fp);
         chk("fp_rst", longint'($rtoi(bus.fp_rst * 1000.0)), 0);
      end
   endtask

   task automatic set_n(input int a, input int b, input int c);
      bus.n_rst    = CW'(a);
      bus.n_fast   = CW'(b);
      bus.n_settle = CW'(c);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, want $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.start = 1'b1;
      bus.abort = 1'b0;
      set_n(4, 8, 2);
      #1;

      // reset held with start asserted
      rst = 1'b1;
      plan(0, 3);
      drain(1'b1);
      rst = 1'b0;
      bus.start = 1'b0;
      plan(0, 2);
      drain(1'b0);

      // nominal 4/8/2 then two quiet LOCKED cycles
      set_n(4, 8, 2);
      bus.start = 1'b1;
      plan_seq(4, 8, 2);
      drain(1'b0);
      plan(4, 2);
      drain(1'b0);

      // zero counts, re-lock from LOCKED
      set_n(0, 0, 0);
      bus.start = 1'b1;
      plan_seq(0, 0, 0);
      drain(1'b0);

      // abort with start in the 3rd FAST cycle
      set_n(4, 8, 2);
      bus.start = 1'b1;
      plan(1, 4);
      plan(2, 2);
      drain(1'b0);
      plan(2, 1);
      drain(1'b0);
      bus.start = 1'b1;
      bus.abort = 1'b1;
      plan(0, 3);
      drain(1'b0);

      // abort in IDLE is harmless
      bus.abort = 1'b1;
      plan(0, 2);
      drain(1'b0);

      // start held throughout, counts changed mid-sequence
      set_n(4, 8, 2);
      bus.start = 1'b1;
      plan(1, 1);
      drain(1'b1);
      set_n(1, 1, 1);
      plan(1, 3);
      plan(2, 8);
      plan(3, 2);
      plan(4, 1, 1'b1);
      drain(1'b1);
      plan_seq(1, 1, 1);
      drain(1'b0);
      plan(4, 1);
      drain(1'b0);

      // max count FAST phase
      set_n(1, 255, 1);
      bus.start = 1'b1;
      plan_seq(1, 255, 1);
      drain(1'b0);
      plan(4, 1);
      drain(1'b0);

      $display("== %0d vectors applied, %0d miscompares ==",
               n_vec, n_err);
      $finish;
   end

endmodule
